// File: rtl/octave_pkg.sv
// Shared types and the octave mixing function for the octave synthesizer.
package octave_pkg;

    localparam int unsigned NUM_OCTAVES = 7;
    localparam int unsigned SAMPLE_W    = 16;
    localparam int unsigned PHASE_W     = 7;

    typedef logic [NUM_OCTAVES-1:0]     oct_mask_t;
    typedef logic signed [SAMPLE_W-1:0] sample_t;

    // Octave k's square wave is phase bit (6-k): octave 6 is the fastest.
    function automatic sample_t mix_sample(oct_mask_t m, logic [PHASE_W-1:0] ph, sample_t amp);
        sample_t acc;
        acc = '0;
        for (int k = 0; k < NUM_OCTAVES; k++) begin
            if (m[k]) begin
                acc = ph[PHASE_W-1-k] ? acc + amp : acc - amp;
            end
        end
        return acc;
    endfunction

endpackage

// File: rtl/octave_synth_if.sv
// Mask-write and sample-stream signals between the CPU/audio path and the synthesizer.
interface octave_synth_if;
    import octave_pkg::*;

    oct_mask_t octaves;
    logic      octaves_en;
    logic      sample_ready;
    logic      overrun_clr;
    logic      sample_valid;
    sample_t   sample_data;
    oct_mask_t active_mask;
    logic      overrun;

    modport master (
        output octaves, octaves_en, sample_ready, overrun_clr,
        input  sample_valid, sample_data, active_mask, overrun
    );

    modport slave (
        input  octaves, octaves_en, sample_ready, overrun_clr,
        output sample_valid, sample_data, active_mask, overrun
    );

endinterface

// File: rtl/octave_synth_tick_div.sv
// Modulo-DIV free-running counter producing a one-cycle pulse on its terminal count.
module tick_div #(
    parameter int unsigned DIV = 2
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int unsigned     CntW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CntW-1:0] Last = CntW'(DIV - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == Last);

    always_comb begin
        cnt_d = tick ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/octave_synth.sv
// Seven-octave square-wave synthesizer: latches the CPU octave mask, mixes the enabled
// octaves into a PCM sample each sample tick and offers it over valid/ready.
module octave_synth
    import octave_pkg::*;
#(
    parameter int unsigned HALF_PERIOD = 28409,
    parameter int unsigned SAMPLE_DIV  = 1134,
    parameter int unsigned AMP         = 4096
) (
    input  logic           clk,
    input  logic           rst,
    octave_synth_if.slave  bus
);

    localparam sample_t AmpS = sample_t'(AMP);

    logic base_tick, sample_tick;

    tick_div #(.DIV(HALF_PERIOD)) u_base_div (
        .clk  (clk),
        .rst  (rst),
        .tick (base_tick)
    );

    tick_div #(.DIV(SAMPLE_DIV)) u_sample_div (
        .clk  (clk),
        .rst  (rst),
        .tick (sample_tick)
    );

    logic [PHASE_W-1:0] ph_q, ph_d;
    oct_mask_t          shadow_q, shadow_d;
    oct_mask_t          active_q, active_d;
    oct_mask_t          mask_in;
    sample_t            data_q, data_d;
    logic               valid_q, valid_d;
    logic               overrun_q, overrun_d;
    logic               drop;

    always_comb begin
        ph_d      = base_tick ? ph_q + 1'b1 : ph_q;
        // A write landing in the tick cycle is applied to that very sample.
        mask_in   = bus.octaves_en ? bus.octaves : shadow_q;
        shadow_d  = mask_in;
        active_d  = active_q;
        data_d    = data_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        drop      = sample_tick && valid_q && !bus.sample_ready;

        if (sample_tick) begin
            active_d = mask_in;
            if (!drop) begin
                data_d  = mix_sample(mask_in, ph_q, AmpS);
                valid_d = 1'b1;
            end
        end else if (valid_q && bus.sample_ready) begin
            valid_d = 1'b0;
        end

        if (bus.overrun_clr) begin
            overrun_d = 1'b0;
        end
        if (drop) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ph_q      <= '0;
            shadow_q  <= '0;
            active_q  <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            ph_q      <= ph_d;
            shadow_q  <= shadow_d;
            active_q  <= active_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign bus.sample_valid = valid_q;
    assign bus.sample_data  = data_q;
    assign bus.active_mask  = active_q;
    assign bus.overrun      = overrun_q;

endmodule

// File: tb/tb_octave_synth.sv
// Self-checking bench for octave_synth: spec-level model with a sample scoreboard,
// a table of mask writes, and hand-written handshake/reset sequences.
module tb_octave_synth;
    import octave_pkg::*;

    localparam int HP  = 4;
    localparam int SD  = 8;
    localparam int AMP = 100;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    octave_synth_if bus ();

    octave_synth #(
        .HALF_PERIOD (HP),
        .SAMPLE_DIV  (SD),
        .AMP         (AMP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int mix(logic [6:0] m, int ph);
        logic [6:0] p;
        int s;
        p = ph[6:0];
        s = 0;
        for (int k = 0; k < 7; k++) begin
            if (m[k]) s += p[6-k] ? AMP : -AMP;
        end
        return s;
    endfunction

    // Model: phase and sample ticks derived from cycles since reset release.
    int        cyc = 0;
    oct_mask_t m_shadow, m_active, mask_now;
    logic      m_valid, m_ovr, tb_tick;
    int        ph_now;
    int        sb[$];

    always_comb begin
        tb_tick  = (cyc % SD) == (SD - 1);
        ph_now   = (cyc / HP) % 128;
        mask_now = bus.octaves_en ? bus.octaves : m_shadow;
    end

    always @(posedge clk) begin
        if (rst) begin
            cyc      <= 0;
            m_shadow <= '0;
            m_active <= '0;
            m_valid  <= 1'b0;
            m_ovr    <= 1'b0;
            sb.delete();
        end else begin
            cyc      <= cyc + 1;
            m_shadow <= mask_now;
            if (tb_tick) begin
                m_active <= mask_now;
                if (m_valid && !bus.sample_ready) begin
                    m_ovr <= 1'b1;
                end else begin
                    m_valid <= 1'b1;
                    sb.push_back(mix(mask_now, ph_now));
                end
            end else if (m_valid && bus.sample_ready) begin
                m_valid <= 1'b0;
            end
            if (!(tb_tick && m_valid && !bus.sample_ready) && bus.overrun_clr) m_ovr <= 1'b0;
        end
    end

    always @(negedge clk) begin
        int e;
        if (!rst) begin
            check("mon_valid", int'(bus.sample_valid), int'(m_valid));
            check("mon_overrun", int'(bus.overrun), int'(m_ovr));
            check("mon_active", int'(bus.active_mask), int'(m_active));
            if (bus.sample_valid && bus.sample_ready) begin
                if (sb.size() == 0) begin
                    check("sb_unexpected_sample", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("sb_sample", int'($signed(bus.sample_data)), e);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic goto_tick();
        for (int i = 0; i < 2 * SD && !tb_tick; i++) step();
        if (!tb_tick) check("goto_tick_timeout", 0, 1);
    endtask

    task automatic wait_valid(string name);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 3 * SD; i++) begin
            @(negedge clk);
            if (bus.sample_valid) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) check(name, 0, 1);
    endtask

    typedef struct {
        logic [6:0] mask;
        int         n_samples;
        bit         chk_first;
        int         first;
        logic [6:0] exp_active;
    } vec_t;

    vec_t vecs[5];
    int   held;
    int   p;

    initial begin
        vecs[0] = '{mask: 7'h01, n_samples: 40, chk_first: 1'b1, first: -100, exp_active: 7'h01};
        vecs[1] = '{mask: 7'h7F, n_samples: 4,  chk_first: 1'b0, first: 0,    exp_active: 7'h7F};
        vecs[2] = '{mask: 7'h2A, n_samples: 3,  chk_first: 1'b0, first: 0,    exp_active: 7'h2A};
        vecs[3] = '{mask: 7'h00, n_samples: 2,  chk_first: 1'b1, first: 0,    exp_active: 7'h00};
        vecs[4] = '{mask: 7'h55, n_samples: 3,  chk_first: 1'b0, first: 0,    exp_active: 7'h55};

        // Reset held two cycles with a write strobe asserted.
        bus.octaves      = 7'h7F;
        bus.octaves_en   = 1'b1;
        bus.sample_ready = 1'b1;
        bus.overrun_clr  = 1'b0;
        rst              = 1'b1;
        step();
        step();
        rst            = 1'b0;
        bus.octaves_en = 1'b0;
        bus.octaves    = '0;
        @(negedge clk);
        check("rst_valid", int'(bus.sample_valid), 0);
        check("rst_data", int'($signed(bus.sample_data)), 0);
        check("rst_active", int'(bus.active_mask), 0);
        check("rst_overrun", int'(bus.overrun), 0);
        wait_valid("rst_first_timeout");
        check("rst_first_sample", int'($signed(bus.sample_data)), 0);

        // Full mask right after reset: ticks land on ph=1 and ph=3.
        step();
        rst = 1'b1;
        step();
        rst            = 1'b0;
        bus.octaves    = 7'h7F;
        bus.octaves_en = 1'b1;
        step();
        bus.octaves_en = 1'b0;
        wait_valid("full_timeout0");
        check("full_ph1", int'($signed(bus.sample_data)), -500);
        check("full_active", int'(bus.active_mask), 32'h7F);
        step();
        wait_valid("full_timeout1");
        check("full_ph3", int'($signed(bus.sample_data)), -300);

        // Table of mask writes with ready held high.
        foreach (vecs[i]) begin
            goto_tick();
            step();
            bus.octaves    = vecs[i].mask;
            bus.octaves_en = 1'b1;
            step();
            bus.octaves_en = 1'b0;
            if (vecs[i].chk_first) begin
                wait_valid("tbl_first_timeout");
                check("tbl_first_sample", int'($signed(bus.sample_data)), vecs[i].first);
            end
            repeat (vecs[i].n_samples * SD) step();
            @(negedge clk);
            check("tbl_active", int'(bus.active_mask), int'(vecs[i].exp_active));
        end

        // Backpressure across two ticks, then clear, then clear colliding with a drop.
        goto_tick();
        step();
        bus.sample_ready = 1'b0;
        held = (sb.size() > 0) ? sb[0] : 32'h7FFF_FFFF;
        repeat (2 * SD) step();
        @(negedge clk);
        check("bp_hold_data", int'($signed(bus.sample_data)), held);
        check("bp_valid", int'(bus.sample_valid), 1);
        check("bp_overrun_set", int'(bus.overrun), 1);
        step();
        bus.overrun_clr = 1'b1;
        step();
        bus.overrun_clr = 1'b0;
        @(negedge clk);
        check("bp_overrun_clr", int'(bus.overrun), 0);
        goto_tick();
        bus.overrun_clr = 1'b1;
        step();
        bus.overrun_clr = 1'b0;
        @(negedge clk);
        check("bp_set_wins", int'(bus.overrun), 1);
        step();
        bus.sample_ready = 1'b1;
        step();
        bus.overrun_clr = 1'b1;
        step();
        bus.overrun_clr = 1'b0;

        // Write in the tick cycle bypasses the shadow register.
        goto_tick();
        bus.octaves    = 7'h40;
        bus.octaves_en = 1'b1;
        p = ph_now;
        step();
        bus.octaves_en = 1'b0;
        @(negedge clk);
        check("sw_active", int'(bus.active_mask), 32'h40);
        check("sw_data", int'($signed(bus.sample_data)), mix(7'h40, p));

        // Accept coinciding with a tick keeps valid high with the new sample.
        step();
        bus.octaves    = 7'h60;
        bus.octaves_en = 1'b1;
        step();
        bus.octaves_en = 1'b0;
        goto_tick();
        step();
        bus.sample_ready = 1'b0;
        goto_tick();
        bus.sample_ready = 1'b1;
        p = ph_now;
        step();
        bus.sample_ready = 1'b0;
        @(negedge clk);
        check("at_valid", int'(bus.sample_valid), 1);
        check("at_data", int'($signed(bus.sample_data)), mix(7'h60, p));
        check("at_overrun", int'(bus.overrun), 0);

        // Reset while a sample is pending discards it.
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_valid", int'(bus.sample_valid), 0);
        check("rst_mid_data", int'($signed(bus.sample_data)), 0);
        check("rst_mid_active", int'(bus.active_mask), 0);
        bus.sample_ready = 1'b1;
        repeat (3 * SD) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
